// File: rtl/pic_draw_pkg.sv
// Shared types and helpers for the picture-blit engine.
package pic_draw_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } draw_state_e;

  localparam int unsigned COORD_W_DEF  = 10;
  localparam int unsigned COLOUR_W_DEF = 3;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Bit width able to hold 0..v-1, never narrower than one bit.
  function automatic int unsigned width_of(input int unsigned v);
    return (clog2(v) < 1) ? 1 : clog2(v);
  endfunction

endpackage

// File: rtl/pic_raster_counter.sv
// Row-major raster counter: cx/cy plus a running linear address (no multiplier).
module pic_raster_counter
  import pic_draw_pkg::*;
#(
  parameter int unsigned IMG_W  = 160,
  parameter int unsigned IMG_H  = 120,
  parameter int unsigned CX_W   = width_of(IMG_W),
  parameter int unsigned CY_W   = width_of(IMG_H),
  parameter int unsigned ADDR_W = width_of(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              clear,
  input  logic              enable,
  output logic [CX_W-1:0]   cx,
  output logic [CY_W-1:0]   cy,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic cx_end;
  logic cy_end;

  assign cx_end = (cx == CX_W'(IMG_W - 1));
  assign cy_end = (cy == CY_W'(IMG_H - 1));
  assign last   = cx_end && cy_end;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cx   <= '0;
      cy   <= '0;
      addr <= '0;
    end else if (enable) begin
      cx <= cx_end ? '0 : cx + 1'b1;
      if (cx_end) begin
        cy <= cy_end ? '0 : cy + 1'b1;
      end
      addr <= last ? '0 : addr + 1'b1;
    end
  end

endmodule

// File: rtl/pic_sweep_drawer.sv
// Picture-blit engine: rasters one stored picture through a latency-matched ROM pipeline.
// Optional build macro PIC_TRANSPARENT_EN suppresses plots of pixels equal to TRANSP_KEY.
module pic_sweep_drawer
  import pic_draw_pkg::*;
#(
  parameter int unsigned IMG_W      = 160,
  parameter int unsigned IMG_H      = 120,
  parameter int unsigned NUM_PICS   = 3,
  parameter int unsigned COLOUR_W   = COLOUR_W_DEF,
  parameter int unsigned COORD_W    = COORD_W_DEF,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned TRANSP_KEY = 0,
  localparam int unsigned ADDR_W    = width_of(IMG_W * IMG_H),
  localparam int unsigned SEL_W     = width_of(NUM_PICS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                abort,
  input  logic [SEL_W-1:0]    pic_sel,
  input  logic [COORD_W-1:0]  x0,
  input  logic [COORD_W-1:0]  y0,
  output logic [SEL_W-1:0]    rom_pic,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [COLOUR_W-1:0] rom_data,
  output logic                plot,
  output logic [COORD_W-1:0]  x,
  output logic [COORD_W-1:0]  y,
  output logic [COLOUR_W-1:0] colour,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CX_W = width_of(IMG_W);
  localparam int unsigned CY_W = width_of(IMG_H);
  localparam logic [COLOUR_W-1:0] KEY = COLOUR_W'(TRANSP_KEY);
`ifdef PIC_TRANSPARENT_EN
  localparam bit TRANSP_ON = 1'b1;
`else
  localparam bit TRANSP_ON = 1'b0;
`endif

  draw_state_e state_q, state_d;

  logic [SEL_W-1:0]   pic_q;
  logic [COORD_W-1:0] x0_q, y0_q;
  logic [2:0]         drain_q;
  logic [ADDR_W-1:0]  addr_hold_q;
  logic               pic_ok;
  logic               issue;
  logic               hit;

  logic [CX_W-1:0]    cnt_cx;
  logic [CY_W-1:0]    cnt_cy;
  logic [ADDR_W-1:0]  cnt_addr;
  logic               cnt_last;

  logic               vld_q [ROM_LAT];
  logic [CX_W-1:0]    cx_pipe_q [ROM_LAT];
  logic [CY_W-1:0]    cy_pipe_q [ROM_LAT];

  assign pic_ok = ({1'b0, pic_sel} < (SEL_W + 1)'(NUM_PICS));

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (go) state_d = pic_ok ? StSweep : StDone;
      end
      StSweep: begin
        issue = !abort;
        if (abort || cnt_last) state_d = StDrain;
      end
      StDrain: begin
        if (drain_q == 3'(ROM_LAT)) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= StIdle;
      pic_q       <= '0;
      x0_q        <= '0;
      y0_q        <= '0;
      drain_q     <= '0;
      addr_hold_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && go && pic_ok) begin
        pic_q <= pic_sel;
        x0_q  <= x0;
        y0_q  <= y0;
      end
      drain_q <= (state_q == StDrain) ? drain_q + 3'd1 : 3'd0;
      if (issue) addr_hold_q <= cnt_addr;
    end
  end

  pic_raster_counter #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .CX_W   (CX_W),
    .CY_W   (CY_W),
    .ADDR_W (ADDR_W)
  ) u_raster (
    .clk    (clk),
    .resetn (resetn),
    .clear  (state_q == StIdle),
    .enable (issue),
    .cx     (cnt_cx),
    .cy     (cnt_cy),
    .addr   (cnt_addr),
    .last   (cnt_last)
  );

  // An aborted slot must not expose its address, so show the last issued one instead.
  assign rom_addr = issue ? cnt_addr : addr_hold_q;
  assign rom_pic  = pic_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < int'(ROM_LAT); i++) begin
        vld_q[i]     <= 1'b0;
        cx_pipe_q[i] <= '0;
        cy_pipe_q[i] <= '0;
      end
    end else begin
      vld_q[0]     <= issue;
      cx_pipe_q[0] <= cnt_cx;
      cy_pipe_q[0] <= cnt_cy;
      for (int i = 1; i < int'(ROM_LAT); i++) begin
        vld_q[i]     <= vld_q[i-1];
        cx_pipe_q[i] <= cx_pipe_q[i-1];
        cy_pipe_q[i] <= cy_pipe_q[i-1];
      end
    end
  end

  assign hit = vld_q[ROM_LAT-1] && !(TRANSP_ON && (rom_data == KEY));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else begin
      plot <= hit;
      if (hit) begin
        x      <= x0_q + COORD_W'(cx_pipe_q[ROM_LAT-1]);
        y      <= y0_q + COORD_W'(cy_pipe_q[ROM_LAT-1]);
        colour <= rom_data;
      end
    end
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_pic_sweep_drawer.sv
// Bench: two engines (ROM latency 1 and 3) share stimulus; each is checked cycle by cycle.
module tb_pic_sweep_drawer;

  localparam int W   = 4;
  localparam int H   = 3;
  localparam int N   = W * H;
  localparam int WIN = 24;
`ifdef PIC_TRANSPARENT_EN
  localparam bit TR = 1'b1;
`else
  localparam bit TR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetn;
  logic       go;
  logic       abort;
  logic [1:0] pic_sel;
  logic [9:0] x0;
  logic [9:0] y0;

  logic [1:0] rom_pic  [2];
  logic [3:0] rom_addr [2];
  logic [2:0] rom_data [2];
  logic       plot     [2];
  logic [9:0] x        [2];
  logic [9:0] y        [2];
  logic [2:0] colour   [2];
  logic       busy     [2];
  logic       done     [2];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int lat       [2] = '{1, 3};
  int prev_addr [2] = '{0, 0};
  int prev_pic  [2] = '{0, 0};
  int hx        [2] = '{0, 0};
  int hy        [2] = '{0, 0};
  int hc        [2] = '{0, 0};

  always #5 clk = ~clk;

  pic_sweep_drawer #(
    .IMG_W(W), .IMG_H(H), .NUM_PICS(3), .COLOUR_W(3), .COORD_W(10), .ROM_LAT(1), .TRANSP_KEY(0)
  ) u_dut1 (
    .clk(clk), .resetn(resetn), .go(go), .abort(abort), .pic_sel(pic_sel), .x0(x0), .y0(y0),
    .rom_pic(rom_pic[0]), .rom_addr(rom_addr[0]), .rom_data(rom_data[0]), .plot(plot[0]),
    .x(x[0]), .y(y[0]), .colour(colour[0]), .busy(busy[0]), .done(done[0])
  );

  pic_sweep_drawer #(
    .IMG_W(W), .IMG_H(H), .NUM_PICS(3), .COLOUR_W(3), .COORD_W(10), .ROM_LAT(3), .TRANSP_KEY(0)
  ) u_dut3 (
    .clk(clk), .resetn(resetn), .go(go), .abort(abort), .pic_sel(pic_sel), .x0(x0), .y0(y0),
    .rom_pic(rom_pic[1]), .rom_addr(rom_addr[1]), .rom_data(rom_data[1]), .plot(plot[1]),
    .x(x[1]), .y(y[1]), .colour(colour[1]), .busy(busy[1]), .done(done[1])
  );

  // ROM models: colour = addr[2:0], delivered after 1 and 3 cycles respectively.
  logic [2:0] rd1_q = 3'd0;
  logic [2:0] rd3_q [3] = '{3'd0, 3'd0, 3'd0};
  always @(posedge clk) begin
    rd1_q    <= rom_addr[0][2:0];
    rd3_q[0] <= rom_addr[1][2:0];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
  end
  assign rom_data[0] = rd1_q;
  assign rom_data[1] = rd3_q[2];

  task automatic chk(input string tag, input int d, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s dut_lat%0d cycle %0d observed %0d expected %0d", tag, lat[d], cyc, obs,
             exp);
    end
  endtask

  task automatic chk_idle_zero(input int d);
    chk("rst_plot", d, 32'(plot[d]), 0);
    chk("rst_busy", d, 32'(busy[d]), 0);
    chk("rst_done", d, 32'(done[d]), 0);
    chk("rst_addr", d, 32'(rom_addr[d]), 0);
    chk("rst_pic", d, 32'(rom_pic[d]), 0);
    chk("rst_x", d, 32'(x[d]), 0);
    chk("rst_y", d, 32'(y[d]), 0);
    chk("rst_colour", d, 32'(colour[d]), 0);
  endtask

  // ab: abort cycle (0 = none); g: cycle of an extra go while busy (0 = none).
  task automatic run_op(input int pic, input int xa, input int ya, input int ab, input int g);
    bit valid, aborted;
    int issued, e, k, ea, ep;
    int done_c [2];
    valid   = (pic < 3);
    aborted = valid && (ab >= 1) && (ab <= N);
    e       = aborted ? ab : N;
    issued  = !valid ? 0 : (aborted ? ab - 1 : N);
    for (int d = 0; d < 2; d++) done_c[d] = valid ? e + lat[d] + 2 : 1;
    @(posedge clk);
    #1;
    for (int c = 0; c < WIN; c++) begin
      cyc     = c;
      go      = (c == 0) || (g != 0 && c == g);
      pic_sel = (c == 0) ? 2'(pic) : 2'($urandom);
      x0      = (c == 0) ? 10'(xa) : 10'($urandom);
      y0      = (c == 0) ? 10'(ya) : 10'($urandom);
      abort   = (ab != 0) && (c == ab);
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        k  = c - lat[d] - 2;
        ep = (valid && k >= 0 && k < issued && !(TR && (k % 8) == 0)) ? 1 : 0;
        if (ep != 0) begin
          hx[d] = (xa + k % W) % 1024;
          hy[d] = (ya + k / W) % 1024;
          hc[d] = k % 8;
        end
        if (c >= 1 && c <= issued) ea = c - 1;
        else if (issued > 0 && c > issued) ea = issued - 1;
        else ea = prev_addr[d];
        chk("plot", d, 32'(plot[d]), 32'(ep));
        chk("x", d, 32'(x[d]), 32'(hx[d]));
        chk("y", d, 32'(y[d]), 32'(hy[d]));
        chk("colour", d, 32'(colour[d]), 32'(hc[d]));
        chk("busy", d, 32'(busy[d]), (c >= 1 && c <= done_c[d]) ? 1 : 0);
        chk("done", d, 32'(done[d]), (c == done_c[d]) ? 1 : 0);
        chk("rom_addr", d, 32'(rom_addr[d]), 32'(ea));
        chk("rom_pic", d, 32'(rom_pic[d]), 32'((valid && c >= 1) ? pic : prev_pic[d]));
      end
      @(posedge clk);
      #1;
    end
    go    = 1'b0;
    abort = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if (issued > 0) prev_addr[d] = issued - 1;
      if (valid) prev_pic[d] = pic;
    end
  endtask

  initial begin
    int pic, ab, g;
    resetn  = 1'b0;
    go      = 1'b0;
    abort   = 1'b0;
    pic_sel = '0;
    x0      = '0;
    y0      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk_idle_zero(d);
    @(posedge clk);
    #1 resetn = 1'b1;

    run_op(1, 10, 20, 0, 0);     // full sweep
    run_op(3, 5, 5, 0, 0);       // invalid select
    run_op(2, 100, 200, 3, 0);   // abort after two addresses
    run_op(0, 1022, 0, 0, 0);    // x wraps
    run_op(1, 7, 9, 0, 2);       // go while busy
    run_op(2, 0, 1022, 12, 3);   // abort on last slot, y wraps

    // Reset mid-sweep: everything clears, no done pulse.
    @(posedge clk);
    #1 go = 1'b1; pic_sel = 2'd2; x0 = 10'd50; y0 = 10'd60;
    @(posedge clk);
    #1 go = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    @(posedge clk);
    #1 resetn = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc = 100 + c;
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk_idle_zero(d);
    end
    for (int d = 0; d < 2; d++) begin
      prev_addr[d] = 0;
      prev_pic[d]  = 0;
      hx[d] = 0;
      hy[d] = 0;
      hc[d] = 0;
    end

    for (int i = 0; i < 20; i++) begin
      pic = int'($urandom_range(0, 3));
      ab  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, N)) : 0;
      g   = (pic < 3 && $urandom_range(0, 1) == 1) ? int'($urandom_range(2, 3)) : 0;
      run_op(pic, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), ab, g);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
